// File: rtl/shot_pkg.sv
// shot_pkg: shared state encodings, default sizes and counter sizing helper for shot capture
// Contents:
//   state_t        IDLE=0, ARMED=1, CAPTURE=2, HOLD=3
//   DEF_NCH/DEF_W  default channel count and magnitude width
//   cnt_width()    bits needed to count up to max(a, b) inclusive
package shot_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;
    localparam int DEF_NCH = 2;
    localparam int DEF_W   = 16;
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction
endpackage

// File: rtl/shot_peak_ch.sv
// shot_peak_ch: single-channel peak register with zero, load and max-update controls
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   zero       force the peak to 0 (highest priority)
//   load       load mag unconditionally
//   upd        take mag when it exceeds the held peak (unsigned)
//   mag        incoming magnitude
//   peak       held peak value
module shot_peak_ch
    import shot_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         zero,
    input  logic         load,
    input  logic         upd,
    input  logic [W-1:0] mag,
    output logic [W-1:0] peak
);
    logic [W-1:0] peak_q, peak_d;
    always_comb begin
        peak_d = zero ? '0 : (load || (upd && mag > peak_q)) ? mag : peak_q;
    end
    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end
    assign peak = peak_q;
endmodule

// File: rtl/shot_capture_nch.sv
// shot_capture_nch: arm/trigger/window/hold sequencer capturing per-channel flick peaks
// Optional feature macro: SHOT_CAPTURE_TIMEOUT_EN (abandon ARMED after TIMEOUT_SAMPLES
// non-triggering channel-0 samples and pulse timeout); undefined, ARMED waits forever.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   arm         debounced arm level, rising edge arms the unit
//   clear       single-cycle abort, returns to IDLE with peaks zeroed
//   in_valid    per-channel sample strobe
//   in_mag      packed magnitudes, channel i at [i*W +: W]
//   peak_out    packed per-channel peaks
//   peak_valid  high in HOLD
//   shot_done   one-cycle pulse on HOLD entry
//   timeout     one-cycle pulse when ARMED times out
//   busy        high in ARMED or CAPTURE
//   state_out   current state encoding
module shot_capture_nch
    import shot_pkg::*;
#(
    parameter int NCH             = DEF_NCH,
    parameter int W               = DEF_W,
    parameter int TRIG_THRESH     = 200,
    parameter int WIN_SAMPLES     = 64,
    parameter int TIMEOUT_SAMPLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             clear,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_mag,
    output logic [NCH*W-1:0] peak_out,
    output logic             peak_valid,
    output logic             shot_done,
    output logic             timeout,
    output logic             busy,
    output logic [1:0]       state_out
);
    localparam int CW = cnt_width(WIN_SAMPLES, TIMEOUT_SAMPLES);
    localparam logic [CW-1:0] WIN_LAST = CW'(WIN_SAMPLES - 1);
`ifdef SHOT_CAPTURE_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_SAMPLES - 1);
`endif
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          arm_d_q, arm_rise;
    logic          shot_done_q, shot_done_d, timeout_q, timeout_d;
    logic          zero, load, upd;
    logic [NCH-1:0] hit;
    assign arm_rise = arm & ~arm_d_q;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign hit[g] = in_valid[g] && (in_mag[g*W +: W] >= W'(TRIG_THRESH));
        // Channels silent in the trigger cycle keep the 0 they were given on arming.
        shot_peak_ch #(.W(W)) u_peak (
            .clk  (clk),
            .rst  (rst),
            .zero (zero),
            .load (load & in_valid[g]),
            .upd  (upd & in_valid[g]),
            .mag  (in_mag[g*W +: W]),
            .peak (peak_out[g*W +: W])
        );
    end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        zero        = 1'b0;
        load        = 1'b0;
        upd         = 1'b0;
        shot_done_d = 1'b0;
        timeout_d   = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            zero    = 1'b1;
        end else begin
            unique case (state_q)
                ST_ARMED: begin
                    if (|hit) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end
`ifdef SHOT_CAPTURE_TIMEOUT_EN
                    else if (in_valid[0]) begin
                        cnt_d = cnt_inc;
                        if (cnt_q == TO_LAST) begin
                            state_d   = ST_IDLE;
                            cnt_d     = '0;
                            timeout_d = 1'b1;
                        end
                    end
`endif
                end
                ST_CAPTURE: begin
                    upd = 1'b1;
                    if (in_valid[0]) begin
                        cnt_d = cnt_inc;
                        if (cnt_q == WIN_LAST) begin
                            state_d     = ST_HOLD;
                            shot_done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (arm_rise) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                        zero    = 1'b1;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            arm_d_q     <= 1'b0;
            shot_done_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arm_d_q     <= arm;
            shot_done_q <= shot_done_d;
            timeout_q   <= timeout_d;
        end
    end
    assign peak_valid = (state_q == ST_HOLD);
    assign busy       = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign state_out  = state_q;
    assign shot_done  = shot_done_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_shot_capture_nch.sv
// tb_shot_capture_nch: scoreboard bench for shot_capture_nch against a behavioural model
module tb_shot_capture_nch;
    localparam int NCH = 2, W = 16, TRIG = 200, WIN = 4, TO = 8;
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAPTURE = 2, M_HOLD = 3;
`ifdef SHOT_CAPTURE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, arm = 1'b0, clear = 1'b0;
    logic [NCH-1:0] in_valid = '0;
    logic [NCH*W-1:0] in_mag = '0;
    logic [NCH*W-1:0] peak_out;
    logic peak_valid, shot_done, timeout, busy;
    logic [1:0] state_out;

    typedef struct {
        int cyc;
        logic [1:0] st;
        logic [NCH*W-1:0] pk;
        logic pv, sd, to, bz;
    } exp_t;
    exp_t sb[$];
    int cyc = 0, checks = 0, errors = 0;
    int m_st = M_IDLE, m_cnt = 0;
    int m_pk[NCH];
    bit m_arm_d = 1'b0;

    shot_capture_nch #(.NCH(NCH), .W(W), .TRIG_THRESH(TRIG), .WIN_SAMPLES(WIN),
                       .TIMEOUT_SAMPLES(TO)) dut (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .in_valid(in_valid),
        .in_mag(in_mag), .peak_out(peak_out), .peak_valid(peak_valid),
        .shot_done(shot_done), .timeout(timeout), .busy(busy), .state_out(state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int mag(input int i);
        return int'(in_mag[i*W +: W]);
    endfunction

    // Applies the current inputs to the model for one clock and queues what the DUT must show after it.
    task automatic model_step();
        exp_t e;
        bit sd = 1'b0, tmo = 1'b0, trig = 1'b0, rise;
        if (rst) begin
            m_st = M_IDLE; m_cnt = 0; m_arm_d = 1'b0;
            foreach (m_pk[i]) m_pk[i] = 0;
        end else begin
            rise = arm && !m_arm_d;
            for (int i = 0; i < NCH; i++) if (in_valid[i] && mag(i) >= TRIG) trig = 1'b1;
            if (clear) begin
                m_st = M_IDLE; m_cnt = 0;
                foreach (m_pk[i]) m_pk[i] = 0;
            end else if (m_st == M_IDLE || m_st == M_HOLD) begin
                if (rise) begin
                    m_st = M_ARMED; m_cnt = 0;
                    foreach (m_pk[i]) m_pk[i] = 0;
                end
            end else if (m_st == M_ARMED) begin
                if (trig) begin
                    m_st = M_CAPTURE; m_cnt = 0;
                    for (int i = 0; i < NCH; i++) m_pk[i] = in_valid[i] ? mag(i) : 0;
                end else if (TO_EN && in_valid[0]) begin
                    m_cnt++;
                    if (m_cnt == TO) begin m_st = M_IDLE; m_cnt = 0; tmo = 1'b1; end
                end
            end else begin
                for (int i = 0; i < NCH; i++) if (in_valid[i] && mag(i) > m_pk[i]) m_pk[i] = mag(i);
                if (in_valid[0]) begin
                    m_cnt++;
                    if (m_cnt == WIN) begin m_st = M_HOLD; sd = 1'b1; end
                end
            end
            m_arm_d = arm;
        end
        e.cyc = cyc + 1;
        e.st = 2'(m_st);
        e.pk = '0;
        for (int i = 0; i < NCH; i++) e.pk[i*W +: W] = W'(m_pk[i]);
        e.pv = (m_st == M_HOLD);
        e.sd = sd;
        e.to = tmo;
        e.bz = (m_st == M_ARMED) || (m_st == M_CAPTURE);
        sb.push_back(e);
    endtask

    task automatic drive(input bit r, input bit a, input bit c, input logic [NCH-1:0] v,
                         input int m0, input int m1);
        @(posedge clk);
        #1;
        rst = r; arm = a; clear = c; in_valid = v;
        in_mag = {W'(m1), W'(m0)};
        model_step();
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("state_out", 64'(state_out), 64'(e.st));
                chk("peak_out", 64'(peak_out), 64'(e.pk));
                chk("peak_valid", 64'(peak_valid), 64'(e.pv));
                chk("shot_done", 64'(shot_done), 64'(e.sd));
                chk("timeout", 64'(timeout), 64'(e.to));
                chk("busy", 64'(busy), 64'(e.bz));
            end
        end
    end

    function automatic int rmag();
        case ($urandom_range(3))
            0: return int'($urandom_range(199));
            1: return int'($urandom_range(210, 190));
            2: return int'($urandom_range(1000));
            default: return int'($urandom_range(65535));
        endcase
    endfunction

    initial begin
        int xs[6] = '{50, 250, 300, 120, 400, 90};
        int ys[6] = '{10, 20, 30, 40, 50, 60};
        bit a_lvl = 1'b0;
        drive(1, 0, 0, 2'b00, 0, 0);
        drive(1, 0, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 2'b11, xs[i], ys[i]);
        drive(0, 1, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b11, 16'hFFFF, 16'hFFFF);
        drive(0, 1, 0, 2'b11, 16'hFFFF, 16'hFFFF);
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b11, 300, 300);
        drive(0, 0, 0, 2'b01, 10, 0);
        drive(0, 1, 1, 2'b11, 500, 500);
        drive(0, 1, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b10, 0, TRIG);
        for (int i = 0; i < WIN; i++) drive(0, 1, 0, 2'b01, 5, 0);
        drive(0, 1, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < TO; i++) drive(0, 1, 0, 2'b01, TRIG - 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 2'b00, 0, 0);
        drive(1, 1, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b00, 0, 0);
        drive(0, 1, 0, 2'b00, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) a_lvl = ~a_lvl;
            drive($urandom_range(499) == 0, a_lvl, $urandom_range(39) == 0,
                  NCH'($urandom), rmag(), rmag());
        end
        repeat (3) @(posedge clk);
        #5;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
